// File: rtl/hh_pkg.sv
// Shared types and constants for the time-multiplexed neuron scheduler.
package hh_pkg;

    localparam int DATA_W = 8;
    localparam logic [DATA_W-1:0] V_RESET_DEF = 8'd0;
    localparam int REFRACT_DEF = 3;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        WRBK
    } state_t;

endpackage

// File: rtl/hh_rr_arb.sv
// Round-robin picker: first requesting id after the last grant, wrapping modulo N.
module hh_rr_arb #(
    parameter int N   = 4,
    parameter int IDW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] last,
    output logic [IDW-1:0] gnt
);

    logic found;
    int   j;

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        j     = 0;
        for (int i = 1; i <= N; i++) begin
            j = (int'(last) + i) % N;
            if (!found && req[IDW'(j)]) begin
                found = 1'b1;
                gnt   = IDW'(j);
            end
        end
    end

endmodule

// File: rtl/hh_scheduler.sv
// Sweeps N virtual neurons through one shared update datapath per tick and
// streams spike events out through a round-robin valid/ready port.
module hh_scheduler
    import hh_pkg::*;
#(
    parameter int                N_NEURONS  = 4,
    parameter int                REFRACT    = REFRACT_DEF,
    parameter logic [DATA_W-1:0] V_RESET    = V_RESET_DEF,
    parameter int                DP_TIMEOUT = 15,
    localparam int               IDW        = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tick,
    input  logic              enable,
    input  logic              cfg_we,
    input  logic [IDW-1:0]    cfg_addr,
    input  logic [DATA_W-1:0] cfg_data,
    output logic              dp_start,
    output logic [DATA_W-1:0] dp_v,
    output logic [DATA_W-1:0] dp_stim,
    input  logic              dp_done,
    input  logic [DATA_W-1:0] dp_v_next,
    input  logic              dp_spike,
    output logic              ev_valid,
    input  logic              ev_ready,
    output logic [IDW-1:0]    ev_id,
    output logic              busy,
    output logic              sweep_done,
    output logic              overrun,
    output logic              ev_drop,
    output logic              dp_err
);

    localparam int RW = (REFRACT > 0) ? $clog2(REFRACT + 1) : 1;
    localparam int CW = $clog2(DP_TIMEOUT + 1);

    state_t            state, state_nx;
    logic [IDW-1:0]    idx;
    logic [CW-1:0]     wait_cnt;
    logic [DATA_W-1:0] v_mem    [N_NEURONS];
    logic [DATA_W-1:0] stim_mem [N_NEURONS];
    logic [RW-1:0]     refr_mem [N_NEURONS];
    logic [DATA_W-1:0] op_v, op_stim, res_v;
    logic              res_spike, res_skip;
    logic [N_NEURONS-1:0] pending, set_vec, clr_vec;
    logic [IDW-1:0]    last_granted, gnt;
    logic              last_idx, timeout, spike_acc, handshake;
    logic [DATA_W-1:0] stim_eff;

    assign last_idx  = (idx == IDW'(N_NEURONS - 1));
    assign timeout   = (wait_cnt == CW'(DP_TIMEOUT)) && !dp_done;
    assign stim_eff  = (refr_mem[idx] != '0) ? '0 : stim_mem[idx];
    assign spike_acc = (state == WRBK) && !res_skip && res_spike && (refr_mem[idx] == '0);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (tick && enable) state_nx = ISSUE;
            ISSUE:   state_nx = WAIT;
            WAIT:    if (dp_done || timeout) state_nx = WRBK;
            WRBK:    state_nx = last_idx ? IDLE : ISSUE;
            default: state_nx = IDLE;
        endcase
    end

    // Operands are live during ISSUE, then held so a cfg write cannot disturb them mid-update.
    assign dp_start   = (state == ISSUE);
    assign dp_v       = (state == ISSUE) ? v_mem[idx] : op_v;
    assign dp_stim    = (state == ISSUE) ? stim_eff   : op_stim;
    assign busy       = (state != IDLE);
    assign sweep_done = (state == WRBK) && last_idx;

    // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            wait_cnt  <= '0;
            op_v      <= '0;
            op_stim   <= '0;
            res_v     <= '0;
            res_spike <= 1'b0;
            res_skip  <= 1'b0;
            overrun   <= 1'b0;
            dp_err    <= 1'b0;
        end else begin
            state <= state_nx;
            if (tick && busy) overrun <= 1'b1;
            case (state)
                IDLE: if (tick && enable) idx <= '0;
                ISSUE: begin
                    op_v     <= v_mem[idx];
                    op_stim  <= stim_eff;
                    wait_cnt <= CW'(1);
                end
                WAIT: begin
                    if (dp_done) begin
                        res_v     <= dp_v_next;
                        res_spike <= dp_spike;
                        res_skip  <= 1'b0;
                        wait_cnt  <= '0;
                    end else if (timeout) begin
                        res_skip  <= 1'b1;
                        dp_err    <= 1'b1;
                        wait_cnt  <= '0;
                    end else begin
                        wait_cnt  <= wait_cnt + 1'b1;
                    end
                end
                WRBK: if (!last_idx) idx <= idx + 1'b1;
                default: ;
            endcase
        end
    end

    // NOTE: the neuron arrays are small flop banks that must come up cleared, so they sit on the async reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_NEURONS; i++) begin
                v_mem[i]    <= '0;
                stim_mem[i] <= '0;
                refr_mem[i] <= '0;
            end
        end else begin
            if (cfg_we) stim_mem[cfg_addr] <= cfg_data;
            if (state == WRBK && !res_skip) begin
                if (spike_acc) begin
                    v_mem[idx]    <= V_RESET;
                    refr_mem[idx] <= RW'(REFRACT);
                end else begin
                    v_mem[idx] <= res_v;
                    if (refr_mem[idx] != '0) refr_mem[idx] <= refr_mem[idx] - 1'b1;
                end
            end
        end
    end

    hh_rr_arb #(.N(N_NEURONS), .IDW(IDW)) u_arb (
        .req  (pending),
        .last (last_granted),
        .gnt  (gnt)
    );

    assign ev_valid  = |pending;
    assign ev_id     = gnt;
    assign handshake = ev_valid && ev_ready;
    assign set_vec   = spike_acc ? (N_NEURONS'(1) << idx) : '0;
    assign clr_vec   = handshake ? (N_NEURONS'(1) << gnt) : '0;

    // Set is OR-ed in after the clear, so a same-cycle set of the granted bit survives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending      <= '0;
            last_granted <= IDW'(N_NEURONS - 1);
            ev_drop      <= 1'b0;
        end else begin
            pending <= (pending & ~clr_vec) | set_vec;
            if (handshake) last_granted <= gnt;
            if (spike_acc && pending[idx] && !clr_vec[idx]) ev_drop <= 1'b1;
        end
    end

endmodule

// File: tb/tb_hh_scheduler.sv
// Self-checking bench for hh_scheduler: scripted and random sweeps against a
// behavioural neuron/event model; the bench itself plays the shared datapath.
module tb_hh_scheduler;

    localparam int N    = 4;
    localparam int REFR = 3;
    localparam int TO   = 15;

    logic       clk = 1'b0, rst_n = 1'b0, tick = 1'b0, enable = 1'b0;
    logic       cfg_we = 1'b0;
    logic [1:0] cfg_addr = '0;
    logic [7:0] cfg_data = '0;
    logic       dp_start;
    logic [7:0] dp_v, dp_stim;
    logic       dp_done = 1'b0;
    logic [7:0] dp_v_next = '0;
    logic       dp_spike = 1'b0;
    logic       ev_valid, ev_ready = 1'b0;
    logic [1:0] ev_id;
    logic       busy, sweep_done, overrun, ev_drop, dp_err;

    hh_scheduler #(.N_NEURONS(N), .REFRACT(REFR), .V_RESET(8'd0), .DP_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .enable(enable),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .dp_start(dp_start), .dp_v(dp_v), .dp_stim(dp_stim),
        .dp_done(dp_done), .dp_v_next(dp_v_next), .dp_spike(dp_spike),
        .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_id(ev_id),
        .busy(busy), .sweep_done(sweep_done), .overrun(overrun),
        .ev_drop(ev_drop), .dp_err(dp_err)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    // Behavioural model state
    int         m_v [N];
    int         m_stim [N];
    int         m_refr [N];
    bit [N-1:0] m_pend;
    int         m_last;
    bit         m_ovr, m_drop, m_err, m_set;
    int         m_set_idx;
    int         cyc = 0, xtick_cyc = -1, sd_count = 0;
    bit         rand_ready = 1'b0;

    function automatic int rr_pick(input bit [N-1:0] p, input int last);
        for (int i = 1; i <= N; i++)
            if (p[(last + i) % N]) return (last + i) % N;
        return 0;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < N; i++) begin
            m_v[i] = 0; m_stim[i] = 0; m_refr[i] = 0;
        end
        m_pend = '0; m_last = N - 1;
        m_ovr = 0; m_drop = 0; m_err = 0; m_set = 0;
    endtask

    // Advance one cycle: model the coming edge from the inputs now driven, then check events.
    task automatic step();
        int g;
        bit clr;
        if (cyc == xtick_cyc) begin tick = 1'b1; m_ovr = 1'b1; end
        if (rand_ready) ev_ready = 1'($urandom_range(0, 1));
        if (rst_n) begin
            g   = rr_pick(m_pend, m_last);
            clr = ev_ready && (m_pend != '0);
            if (m_set && m_pend[m_set_idx] && !(clr && g == m_set_idx)) m_drop = 1'b1;
            if (clr) begin m_pend[g] = 1'b0; m_last = g; end
            if (m_set) m_pend[m_set_idx] = 1'b1;
        end
        m_set = 1'b0;
        @(negedge clk);
        if (cyc == xtick_cyc) tick = 1'b0;
        cyc++;
        if (sweep_done) sd_count++;
        vectors++;
        if (ev_valid !== (m_pend != '0)) begin
            errors++; $display("FAIL ev_valid cyc=%0d: got %b expected %b", cyc, ev_valid, (m_pend != '0));
        end
        if (m_pend != '0) begin
            vectors++;
            if (ev_id !== 2'(rr_pick(m_pend, m_last))) begin
                errors++; $display("FAIL ev_id cyc=%0d: got %0d expected %0d", cyc, ev_id, rr_pick(m_pend, m_last));
            end
        end
        vectors++;
        if (ev_drop !== m_drop) begin
            errors++; $display("FAIL ev_drop cyc=%0d: got %b expected %b", cyc, ev_drop, m_drop);
        end
    endtask

    task automatic cfg_write(input int a, input int d);
        cfg_we = 1'b1; cfg_addr = 2'(a); cfg_data = 8'(d);
        step();
        cfg_we = 1'b0;
        m_stim[a] = d;
    endtask

    // One full sweep. k: dp_done delay; spk: dp_spike per neuron; hold: withhold dp_done;
    // cfgm: cfg write to that neuron during its ISSUE cycle; en_drop: deassert enable mid-sweep.
    task automatic run_sweep(input int k, input bit [N-1:0] spk, input bit [N-1:0] hold,
                             input bit [N-1:0] cfgm, input bit en_drop);
        int t0, sd0, sv, ss, exp_len;
        bit acc;
        sd0 = sd_count; t0 = cyc; exp_len = 0;
        tick = 1'b1; enable = 1'b1;
        step();
        tick = 1'b0;
        if (en_drop) enable = 1'b0;
        for (int n = 0; n < N; n++) begin
            ss = (m_refr[n] != 0) ? 0 : m_stim[n];
            sv = m_v[n];
            exp_len += hold[n] ? (TO + 2) : (k + 2);
            vectors += 3;
            if (dp_start !== 1'b1) begin errors++; $display("FAIL dp_start n=%0d: got %b expected 1", n, dp_start); end
            if (dp_v !== 8'(sv)) begin errors++; $display("FAIL dp_v n=%0d: got %0d expected %0d", n, dp_v, sv); end
            if (dp_stim !== 8'(ss)) begin errors++; $display("FAIL dp_stim n=%0d: got %0d expected %0d", n, dp_stim, ss); end
            if (cfgm[n]) begin cfg_we = 1'b1; cfg_addr = 2'(n); cfg_data = 8'($urandom); end
            step();
            if (cfgm[n]) begin cfg_we = 1'b0; m_stim[n] = int'(cfg_data); end
            vectors++;
            if (dp_start !== 1'b0) begin errors++; $display("FAIL dp_start_pulse n=%0d: got %b expected 0", n, dp_start); end
            if (hold[n]) begin
                for (int w = 2; w <= TO; w++) step();
                step();
                m_err = 1'b1;
                vectors++;
                if (dp_err !== 1'b1) begin errors++; $display("FAIL dp_err n=%0d: got %b expected 1", n, dp_err); end
            end else begin
                for (int j = 1; j < k; j++) step();
                vectors++;
                if (dp_v !== 8'(sv) || dp_stim !== 8'(ss)) begin
                    errors++; $display("FAIL operand_hold n=%0d: got v=%0d s=%0d expected v=%0d s=%0d", n, dp_v, dp_stim, sv, ss);
                end
                dp_done = 1'b1; dp_v_next = 8'(sv + ss); dp_spike = spk[n];
                step();
                dp_done = 1'b0; dp_spike = 1'b0;
                acc = spk[n] && (m_refr[n] == 0);
                if (acc) begin
                    m_v[n] = 0; m_refr[n] = REFR; m_set = 1'b1; m_set_idx = n;
                end else begin
                    m_v[n] = (sv + ss) % 256;
                    if (m_refr[n] != 0) m_refr[n]--;
                end
            end
            vectors += 2;
            if (busy !== 1'b1) begin errors++; $display("FAIL busy_wrbk n=%0d: got %b expected 1", n, busy); end
            if (sweep_done !== (n == N - 1)) begin
                errors++; $display("FAIL sweep_done n=%0d: got %b expected %b", n, sweep_done, (n == N - 1));
            end
            if (n == N - 1) begin
                vectors++;
                if (cyc - t0 !== exp_len) begin errors++; $display("FAIL sweep_latency: got %0d expected %0d", cyc - t0, exp_len); end
            end
            step();
        end
        vectors += 5;
        if (busy !== 1'b0) begin errors++; $display("FAIL busy_idle: got %b expected 0", busy); end
        if (dp_start !== 1'b0) begin errors++; $display("FAIL dp_start_idle: got %b expected 0", dp_start); end
        if (sd_count - sd0 !== 1) begin errors++; $display("FAIL sweep_done_count: got %0d expected 1", sd_count - sd0); end
        if (overrun !== m_ovr) begin errors++; $display("FAIL overrun: got %b expected %b", overrun, m_ovr); end
        if (dp_err !== m_err) begin errors++; $display("FAIL dp_err_sticky: got %b expected %b", dp_err, m_err); end
    endtask

    task automatic idle_check(input int cycles, input string tag);
        int sd0;
        sd0 = sd_count;
        for (int i = 0; i < cycles; i++) begin
            step();
            vectors += 2;
            if (dp_start !== 1'b0) begin errors++; $display("FAIL %s dp_start: got %b expected 0", tag, dp_start); end
            if (busy !== 1'b0) begin errors++; $display("FAIL %s busy: got %b expected 0", tag, busy); end
        end
        vectors++;
        if (sd_count !== sd0) begin errors++; $display("FAIL %s extra_sweep_done: got %0d expected 0", tag, sd_count - sd0); end
    endtask

    task automatic check_all_zero(input string tag);
        vectors++;
        if ({dp_start, dp_v, dp_stim, ev_valid, ev_id, busy, sweep_done, overrun, ev_drop, dp_err} !== '0) begin
            errors++;
            $display("FAIL %s outputs: got start=%b v=%0d stim=%0d evv=%b id=%0d busy=%b sd=%b ovr=%b drop=%b err=%b expected all 0",
                     tag, dp_start, dp_v, dp_stim, ev_valid, ev_id, busy, sweep_done, overrun, ev_drop, dp_err);
        end
    endtask

    task automatic test_reset();
        m_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        idle_check(3, "post_reset");
    endtask

    task automatic test_sweep_basic();
        cfg_write(0, 10); cfg_write(1, 20); cfg_write(2, 30); cfg_write(3, 40);
        run_sweep(2, '0, '0, '0, 1'b0);
        run_sweep(2, '0, '0, 4'b0100, 1'b0);
    endtask

    task automatic test_refractory();
        run_sweep(2, 4'b0100, '0, '0, 1'b0);
        run_sweep(2, 4'b0100, '0, '0, 1'b0);
        run_sweep(3, '0, '0, '0, 1'b0);
        run_sweep(1, 4'b0100, '0, '0, 1'b0);
        run_sweep(2, 4'b0100, '0, '0, 1'b0);
        ev_ready = 1'b1;
        repeat (2) step();
        ev_ready = 1'b0;
    endtask

    task automatic test_overrun();
        xtick_cyc = cyc + 3;
        run_sweep(2, '0, '0, '0, 1'b0);
        xtick_cyc = -1;
        idle_check(5, "overrun");
    endtask

    task automatic test_timeout();
        run_sweep(2, '0, 4'b0010, '0, 1'b1);
        run_sweep(2, '0, '0, '0, 1'b0);
    endtask

    task automatic test_async_reset();
        tick = 1'b1; enable = 1'b1;
        step();
        tick = 1'b0;
        step();
        rst_n = 1'b0;
        m_reset();
        #1;
        check_all_zero("async_reset");
        step();
        rst_n = 1'b1;
        dp_done = 1'b1; dp_v_next = 8'hAA; dp_spike = 1'b1;
        step();
        dp_done = 1'b0; dp_spike = 1'b0;
        check_all_zero("late_dp_done");
        idle_check(4, "late_dp_done");
        run_sweep(2, '0, '0, '0, 1'b0);
    endtask

    task automatic test_event_order();
        int exp_seq [3] = '{0, 1, 3};
        run_sweep(1, 4'b1011, '0, '0, 1'b0);
        ev_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (ev_id !== 2'(exp_seq[i])) begin
                errors++; $display("FAIL ev_order[%0d]: got %0d expected %0d", i, ev_id, exp_seq[i]);
            end
            step();
        end
        vectors++;
        if (ev_valid !== 1'b0) begin errors++; $display("FAIL ev_drained: got %b expected 0", ev_valid); end
        ev_ready = 1'b0;
    endtask

    task automatic test_random();
        rand_ready = 1'b1;
        for (int s = 0; s < 8; s++)
            run_sweep(int'($urandom_range(1, 4)), N'($urandom), '0, N'($urandom), 1'($urandom_range(0, 1)));
        rand_ready = 1'b0;
        ev_ready = 1'b1;
        repeat (N + 1) step();
        ev_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_sweep_basic();
        test_refractory();
        test_overrun();
        test_timeout();
        test_async_reset();
        test_event_order();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
